// File: rtl/uart_rx_interface.sv
// uart_rx_interface
// 8N1 UART receiver for host command bytes (angle setpoints, mode bytes).
// The line is sampled at 16x the bit rate. Each bit is decided by a
// 3-sample majority vote taken in the middle of the bit. Received bytes
// land in a small first-word-fall-through FIFO, so the head byte is always
// visible on 'data' while 'data_rdy' is high.
//
// Handshake (FIFO read side): 'data_rdy' high means 'data' holds a valid
// byte. Asserting 'data_ack' while 'data_rdy' is high pops that byte at the
// next rising edge, and the next entry (if any) appears after that edge.
// 'data_ack' has no effect while 'data_rdy' is low. There is no back-pressure
// toward the line: a byte that arrives while the FIFO is full and is not
// being popped is dropped and flagged on 'overrun'.
module uart_rx_interface #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       UART_RX,
   output logic [7:0] data,
   output logic       data_rdy,
   input  logic       data_ack,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   // ---------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------
   localparam int CLKS_PER_TICK = CLK_FREQ / (BAUD * 16);
   localparam int TICK_W        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W         = PTR_W + 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);
   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

   // Each tick pulse closes one tick period and opens the next one.
   // 'ph_cnt' holds the index of the tick period currently running, so the
   // pulse seen while ph_cnt==k opens tick k+1. The first vote sample is
   // therefore taken on the pulse seen with ph_cnt==6 (opening tick 7), and
   // the decision is made on the pulse seen with ph_cnt==8 (opening tick 9).
   // The pulse seen with ph_cnt==15 ends the bit.
   localparam logic [3:0] PH_SAMPLE_A = 4'd6;
   localparam logic [3:0] PH_SAMPLE_B = 4'd7;
   localparam logic [3:0] PH_DECIDE   = 4'd8;
   localparam logic [3:0] PH_LAST     = 4'd15;

   // ---------------------------------------------------------------------
   // Receiver state
   // ---------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } rx_state_t;

   rx_state_t state;
   rx_state_t state_nxt;

   // Line conditioning
   logic rx_meta;
   logic rx_s;
   logic rx_prev;
   logic start_edge;

   // Timing
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [3:0]        ph_cnt;
   logic              sample_a;
   logic              sample_b;
   logic              decide;
   logic              bit_end;

   // Bit voting and data assembly
   logic       vote_a;
   logic       vote_b;
   logic       majority;
   logic [2:0] bit_cnt;
   logic [7:0] shift_reg;

   // FSM control strobes
   logic clr_cnt;
   logic push_set;
   logic fe_set;

   // FIFO
   logic             push_req;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_full;
   logic             pop;
   logic             do_push;

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------

   // Two-flop synchronizer plus one history flop for start-edge detection;
   // all reset to the idle line level so reset never fakes a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= UART_RX;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = rx_prev & ~rx_s;

   // ---------------------------------------------------------------------
   // Tick generation and bit phase
   // ---------------------------------------------------------------------

   assign tick = (tick_cnt == TICK_LAST);

   // Tick prescaler: free-running, realigned to the frame on a start edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (clr_cnt || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Tick index within the current bit (0..15), realigned on a start edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ph_cnt <= '0;
      end else if (clr_cnt) begin
         ph_cnt <= '0;
      end else if (tick) begin
         ph_cnt <= ph_cnt + 1'b1;
      end
   end

   assign sample_a = tick && (ph_cnt == PH_SAMPLE_A);
   assign sample_b = tick && (ph_cnt == PH_SAMPLE_B);
   assign decide   = tick && (ph_cnt == PH_DECIDE);
   assign bit_end  = tick && (ph_cnt == PH_LAST);

   // Capture the first two vote samples; the third is rx_s itself at the
   // decision pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vote_a <= 1'b1;
         vote_b <= 1'b1;
      end else begin
         if (sample_a) vote_a <= rx_s;
         if (sample_b) vote_b <= rx_s;
      end
   end

   assign majority = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and control strobes.
   always_comb begin
      state_nxt = state;
      clr_cnt   = 1'b0;
      push_set  = 1'b0;
      fe_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               state_nxt = S_START;
               clr_cnt   = 1'b1;
            end
         end
         S_START: begin
            // A start bit that votes high was only a glitch.
            if (decide && majority) begin
               state_nxt = S_IDLE;
            end else if (bit_end) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end && (bit_cnt == 3'd7)) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Leave right at the decision so a short stop bit from the
            // sender still lets the next start edge through.
            if (decide) begin
               if (majority) begin
                  push_set  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  fe_set    = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so it reports only one framing error.
            if (rx_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign rx_busy = (state != S_IDLE);

   // Data bit counter and LSB-first shift register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (clr_cnt) begin
            bit_cnt <= '0;
         end else if ((state == S_DATA) && bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if ((state == S_DATA) && decide) begin
            shift_reg <= {majority, shift_reg[7:1]};
         end
      end
   end

   // Registered push request and framing-error pulse, both one cycle after
   // the stop decision.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         push_req  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push_req  <= push_set;
         frame_err <= fe_set;
      end
   end

   // ---------------------------------------------------------------------
   // First-word-fall-through FIFO
   // ---------------------------------------------------------------------

   assign fifo_full = (count == FIFO_FULL);
   assign data_rdy  = (count != '0);
   assign pop       = data_ack & data_rdy;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push   = push_req & (~fifo_full | pop);
   assign overrun   = push_req & fifo_full & ~pop;

   // Storage array; entries are only visible through the occupancy mask.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign data = data_rdy ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_interface.sv
// Testbench for uart_rx_interface: directed scenarios plus a randomized
// phase, with a scoreboard queue of expected bytes checked by a monitor
// on every FIFO pop.
module tb_uart_rx_interface;

   localparam int CLK_FREQ      = 1_600_000;
   localparam int BAUD          = 10_000;
   localparam int FIFO_DEPTH    = 4;
   localparam int CLKS_PER_TICK = CLK_FREQ / (BAUD * 16);
   localparam int CLKS_PER_BIT  = CLK_FREQ / BAUD;
   // Line drop to data_rdy: 2 sync flops, 1 edge-detect cycle, then the stop
   // bit (bit 9 of the frame) is decided 9 ticks into it, then 1 push clock.
   localparam int LAT_EXP       = 2 + 1 + (9 * 16 + 9) * CLKS_PER_TICK + 1;

   // ---------------- clock / reset ----------------
   logic       clock    = 1'b0;
   logic       reset    = 1'b0;
   logic       UART_RX  = 1'b1;
   logic       data_ack = 1'b0;
   logic [7:0] data;
   logic       data_rdy;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   always #5 clock = ~clock;

   uart_rx_interface #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .UART_RX  (UART_RX),
      .data     (data),
      .data_rdy (data_rdy),
      .data_ack (data_ack),
      .rx_busy  (rx_busy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [7:0] exp_head;
   int checks     = 0;
   int errors     = 0;
   int fe_cycles  = 0;
   int ov_cycles  = 0;
   int exp_fe     = 0;
   int exp_ov     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference model: a valid frame is stored if the FIFO has room,
   // otherwise it is dropped and counted as an overrun.
   task automatic expect_byte(input logic [7:0] b);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      else exp_ov++;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (reset && data_rdy && data_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got 0x%02h, required no byte", data);
         end else begin
            exp_head = exp_q.pop_front();
            if (data !== exp_head) begin
               errors++;
               $display("FAIL pop_data: got 0x%02h, required 0x%02h", data, exp_head);
            end
         end
      end
      if (reset && frame_err) fe_cycles++;
      if (reset && overrun)   ov_cycles++;
      if (reset && (frame_err || overrun)) begin
         checks++;
         if (frame_err && overrun) begin
            errors++;
            $display("FAIL err_exclusive: got frame_err=1 overrun=1, required not both");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clks(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      UART_RX = b;
      clks(CLKS_PER_BIT);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
      UART_RX = 1'b1;
   endtask

   task automatic pop_one(input int budget);
      int n;
      n = 0;
      while (!data_rdy && n < budget) begin
         clks(1);
         n++;
      end
      if (!data_rdy) begin
         checks++;
         errors++;
         $display("FAIL pop_timeout: got data_rdy=0 after %0d cycles, required 1", budget);
      end else begin
         data_ack = 1'b1;
         clks(1);
         data_ack = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ov_base;
      int fe_base;
      int lat;
      bit seen;
      logic [7:0] rb;

      // Reset state
      clks(5);
      check("rst_data", data, 8'h00);
      check("rst_data_rdy", data_rdy, 1'b0);
      check("rst_rx_busy", rx_busy, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      clks(20);

      // Single valid byte with latency measurement
      expect_byte(8'h55);
      fork
         send_frame(8'h55, 1'b1);
         begin
            lat  = 0;
            seen = 1'b0;
            while (lat < 2000 && !seen) begin
               @(negedge clock);
               lat++;
               if (data_rdy) seen = 1'b1;
            end
            check_range("lat_55", lat - 1, LAT_EXP - 10, LAT_EXP + 10);
            check("busy_at_rdy_55", rx_busy, 1'b0);
            check("head_55", data, 8'h55);
         end
      join
      check("fe_after_55", fe_cycles, exp_fe);
      check("ov_after_55", ov_cycles, exp_ov);
      pop_one(200);
      check("empty_after_55", data_rdy, 1'b0);

      // Short low glitch: false start, then a good byte
      clks(200);
      UART_RX = 1'b0;
      clks(3 * CLKS_PER_TICK);
      UART_RX = 1'b1;
      clks(20);
      check("glitch_busy_hi", rx_busy, 1'b1);
      clks(100);
      check("glitch_busy_lo", rx_busy, 1'b0);
      check("glitch_no_rdy", data_rdy, 1'b0);
      check("glitch_no_fe", fe_cycles, exp_fe);
      clks(100);
      expect_byte(8'hA3);
      send_frame(8'hA3, 1'b1);
      pop_one(200);
      check("empty_after_a3", data_rdy, 1'b0);

      // Framing error with the line held low for 20 bit times
      fe_base = fe_cycles;
      exp_fe++;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(rb_const(8'h3C, i));
      UART_RX = 1'b0;
      clks(20 * CLKS_PER_BIT);
      UART_RX = 1'b1;
      clks(50);
      check("fe_one_pulse", fe_cycles - fe_base, 1);
      check("fe_no_rdy", data_rdy, 1'b0);
      check("fe_idle_after", rx_busy, 1'b0);
      clks(100);
      expect_byte(8'h7E);
      send_frame(8'h7E, 1'b1);
      pop_one(200);
      check("empty_after_7e", data_rdy, 1'b0);

      // Overrun: five back-to-back bytes, no acks
      ov_base = ov_cycles;
      for (int b = 1; b <= 5; b++) begin
         expect_byte(8'(b));
         send_frame(8'(b), 1'b1);
         if (b == 4) check("ov_before_5th", ov_cycles - ov_base, 0);
      end
      clks(20);
      check("ov_on_5th", ov_cycles - ov_base, 1);
      for (int i = 0; i < 4; i++) pop_one(50);
      check("empty_after_ov", data_rdy, 1'b0);

      // Full FIFO, pop in the exact push cycle of a 5th byte
      clks(100);
      for (int b = 1; b <= 4; b++) begin
         expect_byte(8'(b));
         send_frame(8'(b), 1'b1);
      end
      ov_base = ov_cycles;
      exp_q.push_back(8'h99);   // the simultaneous pop frees the slot
      fork
         send_frame(8'h99, 1'b1);
         begin
            int n;
            n = 0;
            while (!rx_busy && n < 100) begin clks(1); n++; end
            n = 0;
            while (rx_busy && n < 2000) begin clks(1); n++; end
            if (rx_busy) begin
               checks++;
               errors++;
               $display("FAIL simul_wait: got rx_busy=1, required 0 within budget");
            end else begin
               data_ack = 1'b1;
               clks(1);
               data_ack = 1'b0;
               check("simul_head_02", data, 8'h02);
               check("simul_full_rdy", data_rdy, 1'b1);
            end
         end
      join
      check("simul_no_ov", ov_cycles - ov_base, 0);
      for (int i = 0; i < 4; i++) pop_one(50);
      check("empty_after_simul", data_rdy, 1'b0);

      // Asynchronous reset in the middle of bit 4 with two bytes queued
      clks(100);
      expect_byte(8'h11);
      send_frame(8'h11, 1'b1);
      expect_byte(8'h22);
      send_frame(8'h22, 1'b1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(rb_const(8'hC6, i));
      UART_RX = rb_const(8'hC6, 4);
      clks(CLKS_PER_BIT / 2);
      #2;
      reset = 1'b0;
      #1;
      check("arst_data", data, 8'h00);
      check("arst_data_rdy", data_rdy, 1'b0);
      check("arst_rx_busy", rx_busy, 1'b0);
      check("arst_frame_err", frame_err, 1'b0);
      check("arst_overrun", overrun, 1'b0);
      exp_q.delete();
      UART_RX = 1'b1;
      clks(10);
      reset = 1'b1;
      clks(50);
      expect_byte(8'h42);
      send_frame(8'h42, 1'b1);
      pop_one(200);
      check("empty_after_42", data_rdy, 1'b0);

      // Randomized bytes and gaps with a concurrent random-paced consumer
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               rb = 8'($urandom_range(0, 255));
               expect_byte(rb);
               send_frame(rb, 1'b1);
               clks($urandom_range(0, 2 * CLKS_PER_BIT));
            end
         end
         begin
            for (int i = 0; i < 10; i++) begin
               clks($urandom_range(0, 40));
               pop_one(5000);
            end
         end
      join
      clks(20);

      check("final_q_empty", exp_q.size(), 0);
      check("final_rdy", data_rdy, 1'b0);
      check("final_fe", fe_cycles, exp_fe);
      check("final_ov", ov_cycles, exp_ov);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bit i of a byte constant, kept in a variable so it can be indexed.
   function automatic logic rb_const(input logic [7:0] b, input int i);
      logic [7:0] v;
      v = b;
      return v[i];
   endfunction

endmodule
